// File: rtl/serial_pkg.sv
// serial_pkg: shared types and constants for the serial link transmit/receive blocks
package serial_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;
  localparam int OVERSAMPLE = 16;
  localparam int DATA_BITS = 8;
  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_LVL = 1'b0;
  localparam logic STOP_LVL = 1'b1;
endpackage

// File: rtl/bit_timer.sv
// bit_timer: mod-N counter with synchronous clear; tick marks the last clock of a bit time
import serial_pkg::*;
module bit_timer #(
  parameter int N = OVERSAMPLE
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);
  localparam int W = $clog2(N);
  logic [W-1:0] cnt;
  assign tick = cnt == W'(N - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else cnt <= (clr || tick) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/serial_transmit.sv
// serial_transmit: serializes a byte into start/data(LSB first)/stop frame, OVERSAMPLE clocks per bit.
// Define TX_PARITY_EN to insert an even-parity bit between data and stop.
import serial_pkg::*;
module serial_transmit #(
  parameter int OVERSAMPLE = serial_pkg::OVERSAMPLE,
  parameter int DATA_BITS = serial_pkg::DATA_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [DATA_BITS-1:0] parallelDataIn,
  output logic                 serialDataOut,
  output logic                 busy,
  output logic                 charSent
);
  localparam int IW = $clog2(DATA_BITS);
  tx_state_t state, state_n;
  logic [DATA_BITS-1:0] shift, shift_n;
  logic [IW-1:0] idx, idx_n;
  logic sdo_n, busy_n, sent_n, accept, tick;
`ifdef TX_PARITY_EN
  logic par;
  always_ff @(posedge clk or posedge rst)
    if (rst) par <= 1'b0;
    else if (accept) par <= ^parallelDataIn;
`endif
  bit_timer #(.N(OVERSAMPLE)) u_timer (.clk(clk), .rst(rst), .clr(accept), .tick(tick));
  assign accept = state == IDLE && load;
  always_comb begin
    state_n = state;
    shift_n = shift;
    idx_n = idx;
    sdo_n = serialDataOut;
    busy_n = busy;
    sent_n = 1'b0;
    case (state)
      IDLE: if (load) begin
        state_n = START;
        shift_n = parallelDataIn;
        idx_n = '0;
        sdo_n = START_LVL;
        busy_n = 1'b1;
      end
      START: if (tick) begin
        state_n = DATA;
        sdo_n = shift[0];
      end
      DATA: if (tick) begin
        shift_n = shift >> 1;
        if (idx == IW'(DATA_BITS - 1)) begin
`ifdef TX_PARITY_EN
          state_n = PARITY;
          sdo_n = par;
`else
          state_n = STOP;
          sdo_n = STOP_LVL;
`endif
        end else begin
          idx_n = idx + 1'b1;
          sdo_n = shift[1];
        end
      end
`ifdef TX_PARITY_EN
      PARITY: if (tick) begin
        state_n = STOP;
        sdo_n = STOP_LVL;
      end
`endif
      STOP: if (tick) begin
        state_n = IDLE;
        sdo_n = LINE_IDLE;
        busy_n = 1'b0;
        sent_n = 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      shift <= '0;
      idx <= '0;
      serialDataOut <= LINE_IDLE;
      busy <= 1'b0;
      charSent <= 1'b0;
    end else begin
      state <= state_n;
      shift <= shift_n;
      idx <= idx_n;
      serialDataOut <= sdo_n;
      busy <= busy_n;
      charSent <= sent_n;
    end
endmodule
